// File: rtl/axis_cdc_rx_buffer_pkg.sv
// ---------------------------------------------------------------------------
// axis_cdc_rx_buffer_pkg
// Shared constants for the AXI-stream CDC receive path.
//   AXIS_CDC_RX_MIN_DEPTH : smallest legal FIFO depth of the rx buffer
//   is_pow2()             : elaboration helper used to validate DEPTH
// ---------------------------------------------------------------------------
package axis_cdc_rx_buffer_pkg;

  localparam int AXIS_CDC_RX_MIN_DEPTH = 32'sd2;

  // True when value is a non-zero power of two.
  function automatic logic is_pow2(input int unsigned value);
    return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
  endfunction

endpackage : axis_cdc_rx_buffer_pkg

// File: rtl/axis_cdc_rx_buffer_if.sv
// ---------------------------------------------------------------------------
// axi_stream
// Minimal AXI-stream bundle: valid/ready handshake plus data, user, dest.
//   master modport : drives valid/data/user/dest, receives ready
//   slave  modport : receives valid/data/user/dest, drives ready
// ---------------------------------------------------------------------------
interface axi_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 32,
  parameter int DEST_WIDTH = 32
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [USER_WIDTH-1:0] user;
  logic [DEST_WIDTH-1:0] dest;

  modport master (
    output valid,
    output data,
    output user,
    output dest,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  user,
    input  dest,
    output ready
  );

endinterface : axi_stream

// File: rtl/axis_cdc_rx_buffer_mem.sv
// ---------------------------------------------------------------------------
// axis_cdc_rx_buffer_mem
// DEPTH x WIDTH register array for the rx buffer. Contents are not reset.
//   clock   : destination-domain clock
//   wr_en   : write strobe, writes wr_data at wr_addr on the rising edge
//   wr_addr : write index
//   wr_data : packed {data, user, dest} word
//   rd_addr : read index
//   rd_data : asynchronous read of the entry at rd_addr
// ---------------------------------------------------------------------------
module axis_cdc_rx_buffer_mem
  import axis_cdc_rx_buffer_pkg::*;
#(
  parameter int WIDTH  = 96,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: capture the incoming word into the addressed entry.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end else begin
      mem_q[wr_addr] <= mem_q[wr_addr];
    end
  end

  // Fall-through read: the head entry is visible without a clock edge.
  assign rd_data = mem_q[rd_addr];

endmodule : axis_cdc_rx_buffer_mem

// File: rtl/axis_cdc_rx_buffer.sv
// ---------------------------------------------------------------------------
// axis_cdc_rx_buffer
// Elastic buffer behind a non-back-pressurable CDC. Every in.valid strobe is
// captured into a circular FIFO and replayed as a ready/valid stream; words
// arriving while full (and with no simultaneous pop) are dropped and counted.
//   clock        : destination-domain clock
//   reset        : synchronous, active-low
//   in           : slave stream from the CDC; valid is a strobe
//   out          : master stream, first-word fall-through
//   clear_status : clears overflow and drop_count (a same-cycle drop wins)
//   overflow     : sticky drop flag
//   drop_count   : saturating dropped-word count
//   occupancy    : stored words, 0..DEPTH
// ---------------------------------------------------------------------------
module axis_cdc_rx_buffer
  import axis_cdc_rx_buffer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int USER_WIDTH     = 32,
  parameter int DEST_WIDTH     = 32,
  parameter int DEPTH          = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  axi_stream.slave                  in,
  axi_stream.master                 out,
  input  logic                      clear_status,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int PAY_W = DATA_WIDTH + USER_WIDTH + DEST_WIDTH;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};

  if (!is_pow2(DEPTH) || (DEPTH < AXIS_CDC_RX_MIN_DEPTH)) begin : g_bad_depth
    $error("axis_cdc_rx_buffer: DEPTH must be a power of two and at least AXIS_CDC_RX_MIN_DEPTH");
  end

  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]          occ_q, occ_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      in_ready_q, in_ready_d;

  logic                      full_s;
  logic                      pop_s;
  logic                      push_s;
  logic                      drop_s;
  logic [PAY_W-1:0]          wr_data_s;
  logic [PAY_W-1:0]          rd_data_s;

  // Handshake decode: a pop frees a slot in the same cycle, so a strobe
  // arriving while full is still accepted if the consumer takes the head.
  always_comb begin
    full_s    = (occ_q == OCC_FULL);
    pop_s     = (occ_q != OCC_ZERO) && out.ready;
    push_s    = in.valid && (!full_s || pop_s);
    drop_s    = in.valid && full_s && !pop_s;
    wr_data_s = {in.data, in.user, in.dest};
  end

  // Next-state logic for pointers, occupancy, status and the ready hint.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    // A drop in the same cycle as clear_status restarts the count at one.
    if (drop_s) begin
      overflow_d = 1'b1;
      if (clear_status) begin
        drop_cnt_d = DROP_CNT_WIDTH'(1);
      end else if (&drop_cnt_q) begin
        drop_cnt_d = drop_cnt_q;
      end else begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
      end
    end else if (clear_status) begin
      overflow_d = 1'b0;
      drop_cnt_d = {DROP_CNT_WIDTH{1'b0}};
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end

    in_ready_d = (occ_d != OCC_FULL);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      occ_q      <= OCC_ZERO;
      overflow_q <= 1'b0;
      drop_cnt_q <= {DROP_CNT_WIDTH{1'b0}};
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  axis_cdc_rx_buffer_mem #(
    .WIDTH  (PAY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data_s),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data_s)
  );

  assign out.valid  = (occ_q != OCC_ZERO);
  assign out.data   = rd_data_s[PAY_W-1 -: DATA_WIDTH];
  assign out.user   = rd_data_s[DEST_WIDTH +: USER_WIDTH];
  assign out.dest   = rd_data_s[DEST_WIDTH-1:0];
  assign in.ready   = in_ready_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;
  assign occupancy  = occ_q;

endmodule : axis_cdc_rx_buffer

// File: tb/tb_axis_cdc_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_axis_cdc_rx_buffer
// Table of per-cycle vectors with expected status, a reference queue that
// scores every head-of-FIFO payload, and hand-written wrap/reset sequences.
// ---------------------------------------------------------------------------
module tb_axis_cdc_rx_buffer;
  import axis_cdc_rx_buffer_pkg::*;

  localparam int DW    = 32;
  localparam int UW    = 32;
  localparam int SW    = 32;
  localparam int DEPTH = 8;
  localparam int DCW   = 16;

  typedef logic [DW+UW+SW-1:0] pay_t;

  typedef struct {
    logic        iv;
    logic [31:0] data;
    logic [31:0] dest;
    logic        ordy;
    logic        clr;
    int          occ;
    logic        ovf;
    int          drops;
    logic        irdy;
    logic        ovalid;
  } vec_t;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           clear_status = 1'b0;
  logic           overflow;
  logic [DCW-1:0] drop_count;
  logic [3:0]     occupancy;

  axi_stream #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEST_WIDTH(SW)) in_if ();
  axi_stream #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEST_WIDTH(SW)) out_if ();

  axis_cdc_rx_buffer #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEST_WIDTH(SW),
    .DEPTH(DEPTH), .DROP_CNT_WIDTH(DCW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in           (in_if),
    .out          (out_if),
    .clear_status (clear_status),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .occupancy    (occupancy)
  );

  always #5 clock = ~clock;

  int   checks   = 0;
  int   failures = 0;
  pay_t sb[$];
  logic m_ovf   = 1'b0;
  int   m_drops = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] data, input logic [31:0] dest,
                              input logic ordy, input logic clr, input int occ, input logic ovf,
                              input int drops, input logic irdy, input logic ovalid);
    vec_t v;
    v.iv = iv; v.data = data; v.dest = dest; v.ordy = ordy; v.clr = clr;
    v.occ = occ; v.ovf = ovf; v.drops = drops; v.irdy = irdy; v.ovalid = ovalid;
    return v;
  endfunction

  // One clock: drive inputs, score the head word, advance the reference model.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic [31:0] ds,
                     input logic ordy, input logic clr);
    logic pop;
    logic full;
    in_if.valid  = iv;
    in_if.data   = d;
    in_if.user   = ~d;
    in_if.dest   = ds;
    out_if.ready = ordy;
    clear_status = clr;
    #1;
    pop  = (sb.size() != 0) && ordy;
    full = (sb.size() == DEPTH);
    if (sb.size() != 0) begin
      check("head_valid", out_if.valid, 1'b1);
      check("head_payload", {out_if.data, out_if.user, out_if.dest}, sb[0]);
    end else begin
      check("empty_valid", out_if.valid, 1'b0);
    end
    @(posedge clock);
    if (pop) void'(sb.pop_front());
    if (iv && (!full || pop)) sb.push_back({d, ~d, ds});
    if (iv && full && !pop) begin
      m_ovf   = 1'b1;
      m_drops = clr ? 1 : ((m_drops == 65535) ? m_drops : m_drops + 1);
    end else if (clr) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_occ"}, occupancy, sb.size());
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_drops"}, drop_count, m_drops);
    check({tag, "_in_ready"}, in_if.ready, (sb.size() != DEPTH));
  endtask

  initial begin
    in_if.valid  = 1'b0;
    in_if.data   = 32'd0;
    in_if.user   = 32'd0;
    in_if.dest   = 32'd0;
    out_if.ready = 1'b0;

    // single word, then drain
    vecs.push_back(mk(1'b1, 32'hA5A5_0001, 32'd3, 1'b1, 1'b0, 1, 1'b0, 0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'd0,         32'd0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0));
    // fill with 0..7 while stalled
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back(mk(1'b1, 32'(i), 32'(i), 1'b0, 1'b0, i + 1, 1'b0, 0, (i != DEPTH - 1), 1'b1));
    // three drops while full
    for (int k = 1; k <= 3; k++)
      vecs.push_back(mk(1'b1, 32'h100 + 32'(k), 32'd9, 1'b0, 1'b0, DEPTH, 1'b1, k, 1'b0, 1'b1));
    // clear, then drop together with clear, then clear again
    vecs.push_back(mk(1'b0, 32'd0,      32'd0, 1'b0, 1'b1, DEPTH, 1'b0, 0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 32'h200,    32'd1, 1'b0, 1'b1, DEPTH, 1'b1, 1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'd0,      32'd0, 1'b0, 1'b1, DEPTH, 1'b0, 0, 1'b0, 1'b1));
    // full with simultaneous pop accepts 0x55
    vecs.push_back(mk(1'b1, 32'h55,     32'd5, 1'b1, 1'b0, DEPTH, 1'b0, 0, 1'b0, 1'b1));
    // drain: 1..7 then 0x55 on consecutive cycles
    for (int i = 1; i <= DEPTH; i++)
      vecs.push_back(mk(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, DEPTH - i, 1'b0, 0, 1'b1, (i != DEPTH)));
    // empty boundary: push with ready produces no pop
    vecs.push_back(mk(1'b1, 32'h77,     32'd7, 1'b1, 1'b0, 1, 1'b0, 0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'd0,      32'd0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0));

    // reset state
    @(posedge clock);
    @(posedge clock);
    #1;
    check("rst_out_valid", out_if.valid, 1'b0);
    check("rst_in_ready", in_if.ready, 1'b1);
    check("rst_occ", occupancy, 4'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_drops", drop_count, 16'd0);
    reset = 1'b1;

    foreach (vecs[n]) begin
      cyc(vecs[n].iv, vecs[n].data, vecs[n].dest, vecs[n].ordy, vecs[n].clr);
      check($sformatf("v%0d_occ", n), occupancy, vecs[n].occ);
      check($sformatf("v%0d_ovf", n), overflow, vecs[n].ovf);
      check($sformatf("v%0d_drops", n), drop_count, vecs[n].drops);
      check($sformatf("v%0d_in_ready", n), in_if.ready, vecs[n].irdy);
      check($sformatf("v%0d_out_valid", n), out_if.valid, vecs[n].ovalid);
    end

    // wrap-around: 20 back-to-back strobes with ready held high
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'hC000_0000 + 32'(i), 32'(i), 1'b1, 1'b0);
      check("wrap_occ_le1", (occupancy <= 4'd1), 1'b1);
      check_model("wrap");
    end
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check_model("wrap_end");
    check("wrap_sb_empty", sb.size(), 0);

    // reset mid-operation with five words stored
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'hD000_0000 + 32'(i), 32'd2, 1'b0, 1'b0);
    check_model("pre_rst");
    in_if.valid = 1'b0;
    reset       = 1'b0;
    @(posedge clock);
    #1;
    sb.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
    check("mid_rst_out_valid", out_if.valid, 1'b0);
    check("mid_rst_occ", occupancy, 4'd0);
    check("mid_rst_in_ready", in_if.ready, 1'b1);
    reset = 1'b1;
    cyc(1'b1, 32'hBEEF_0001, 32'd4, 1'b1, 1'b0);
    check_model("post_rst_push");
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check_model("post_rst_pop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_axis_cdc_rx_buffer
